// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin (burst-limited) sharing of one memory port between
//            two requesters, with read responses routed back to the issuer.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int BURST  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_val,
   output logic              req0_rdy,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic              req0_wen,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              resp0_val,
   output logic [DATA_W-1:0] resp0_data,
   input  logic              req1_val,
   output logic              req1_rdy,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic              req1_wen,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              resp1_val,
   output logic [DATA_W-1:0] resp1_data,
   output logic              memreq_val,
   output logic [ADDR_W-1:0] memreq_addr,
   output logic              memreq_wen,
   output logic [DATA_W-1:0] memreq_wdata,
   input  logic [DATA_W-1:0] memresp_data
);

   localparam int               CNT_W   = (BURST < 2) ? 1 : $clog2(BURST + 1);
   localparam logic [CNT_W-1:0] C_BURST = CNT_W'(BURST);
   localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             owner_q, owner_d;
   logic             gnt1;
   logic             accept;

   always_comb begin
      if (req0_val && req1_val)
         gnt1 = (cnt_q < C_BURST) ? last_q : ~last_q;
      else
         gnt1 = req1_val;

      // rst is active-low: nothing is granted while it is held
      accept   = (req0_val | req1_val) & rst;
      req0_rdy = accept & ~gnt1;
      req1_rdy = accept & gnt1;

      memreq_val   = accept;
      memreq_addr  = '0;
      memreq_wen   = 1'b0;
      memreq_wdata = '0;
      if (accept) begin
         memreq_addr  = gnt1 ? req1_addr  : req0_addr;
         memreq_wen   = gnt1 ? req1_wen   : req0_wen;
         memreq_wdata = gnt1 ? req1_wdata : req0_wdata;
      end

      last_d  = last_q;
      cnt_d   = cnt_q;
      pend_d  = 1'b0;
      owner_d = owner_q;
      if (accept) begin
         last_d = gnt1;
         if (gnt1 == last_q)
            cnt_d = (cnt_q == C_BURST) ? C_BURST : cnt_q + C_ONE;
         else
            cnt_d = C_ONE;
         pend_d  = ~memreq_wen;
         owner_d = gnt1;
      end

      resp0_val  = pend_q & ~owner_q;
      resp1_val  = pend_q & owner_q;
      resp0_data = resp0_val ? memresp_data : '0;
      resp1_data = resp1_val ? memresp_data : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q  <= 1'b1;
         cnt_q   <= C_BURST;
         pend_q  <= 1'b0;
         owner_q <= 1'b0;
      end else begin
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         owner_q <= owner_d;
      end
   end

`ifndef SYNTHESIS
   // A stalled request must keep its payload until it is accepted
   a_hold0: assert property (@(posedge clk) disable iff (!rst)
      (req0_val && !req0_rdy) |=> (!req0_val || $stable({req0_addr, req0_wen, req0_wdata})));
   a_hold1: assert property (@(posedge clk) disable iff (!rst)
      (req1_val && !req1_rdy) |=> (!req1_val || $stable({req1_addr, req1_wen, req1_wdata})));
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Scoreboard bench for mem_port_arbiter (directed + random traffic).
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int BURST  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              req0_val, req0_rdy, req0_wen, resp0_val;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata, resp0_data;
   logic              req1_val, req1_rdy, req1_wen, resp1_val;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata, resp1_data;
   logic              memreq_val, memreq_wen;
   logic [ADDR_W-1:0] memreq_addr;
   logic [DATA_W-1:0] memreq_wdata;
   logic [DATA_W-1:0] memresp_data;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST)) dut (
      .clk(clk), .rst(rst),
      .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_addr(req0_addr),
      .req0_wen(req0_wen), .req0_wdata(req0_wdata),
      .resp0_val(resp0_val), .resp0_data(resp0_data),
      .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_addr(req1_addr),
      .req1_wen(req1_wen), .req1_wdata(req1_wdata),
      .resp1_val(resp1_val), .resp1_data(resp1_data),
      .memreq_val(memreq_val), .memreq_addr(memreq_addr), .memreq_wen(memreq_wen),
      .memreq_wdata(memreq_wdata), .memresp_data(memresp_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;

   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      int          port;
      logic [31:0] data;
      int          due;
   } exp_t;
   exp_t sb[$];

   function automatic logic [31:0] init_val(input int i);
      return (i == 0) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0101_0101;
   endfunction

   // Memory environment: read data appears on the cycle after the request
   logic [31:0] mem_env [16];
   initial for (int i = 0; i < 16; i++) mem_env[i] = init_val(i);
   always @(posedge clk) begin
      if (memreq_val && memreq_wen) mem_env[memreq_addr[3:0]] <= memreq_wdata;
      if (memreq_val && !memreq_wen) memresp_data <= mem_env[memreq_addr[3:0]];
      else memresp_data <= $urandom;
   end

   // Reference model: what memory should hold and who owns the current run
   logic [31:0] model_mem [16];
   int          run_port;
   int          run_len;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic drive_cycle(input logic v0, input logic [15:0] a0, input logic w0,
                              input logic [31:0] d0, input logic v1, input logic [15:0] a1,
                              input logic w1, input logic [31:0] d1, output int g);
      logic [15:0] ga;
      logic        gw;
      logic [31:0] gd;
      @(negedge clk);
      req0_val = v0; req0_addr = a0; req0_wen = w0; req0_wdata = d0;
      req1_val = v1; req1_addr = a1; req1_wen = w1; req1_wdata = d1;
      #1;
      if (!v0 && !v1)     g = -1;
      else if (!v1)       g = 0;
      else if (!v0)       g = 1;
      else if (run_len < BURST) g = run_port;
      else                g = 1 - run_port;
      chk("req0_rdy", req0_rdy, g == 0);
      chk("req1_rdy", req1_rdy, g == 1);
      chk("memreq_val", memreq_val, g >= 0);
      ga = (g == 1) ? a1 : (g == 0) ? a0 : 16'h0;
      gw = (g == 1) ? w1 : (g == 0) ? w0 : 1'b0;
      gd = (g == 1) ? d1 : (g == 0) ? d0 : 32'h0;
      chk("memreq_addr", memreq_addr, ga);
      chk("memreq_wen", memreq_wen, gw);
      chk("memreq_wdata", memreq_wdata, gd);
      if (g >= 0) begin
         if (g == run_port) run_len = (run_len < BURST) ? run_len + 1 : BURST;
         else run_len = 1;
         run_port = g;
         if (gw) model_mem[ga[3:0]] = gd;
         else    sb.push_back('{port: g, data: model_mem[ga[3:0]], due: cyc + 1});
      end
   endtask

   // Monitor: each cycle either the head of the scoreboard is due or nothing is
   logic        m_e0, m_e1;
   logic [31:0] m_d;
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (mon_en) begin
            m_e0 = 1'b0; m_e1 = 1'b0; m_d = 32'h0;
            if (sb.size() > 0 && sb[0].due <= cyc) begin
               chk("resp_due", 64'(sb[0].due), 64'(cyc));
               m_e0 = (sb[0].port == 0);
               m_e1 = (sb[0].port == 1);
               m_d  = sb[0].data;
               void'(sb.pop_front());
            end
            chk("resp0_val", resp0_val, m_e0);
            chk("resp1_val", resp1_val, m_e1);
            chk("resp0_data", resp0_data, m_e0 ? m_d : 32'h0);
            chk("resp1_data", resp1_data, m_e1 ? m_d : 32'h0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   bit          hv [2];
   logic [15:0] ha [2];
   logic        hw [2];
   logic [31:0] hd [2];
   logic [9:0]  tie_tbl;
   int          g;

   initial begin
      for (int i = 0; i < 16; i++) model_mem[i] = init_val(i);
      run_port = 1; run_len = BURST;

      // Reset holds every grant and response low even with requests present
      rst = 1'b0;
      req0_val = 1'b1; req0_addr = 16'h0010; req0_wen = 1'b0; req0_wdata = '0;
      req1_val = 1'b1; req1_addr = 16'h0011; req1_wen = 1'b0; req1_wdata = '0;
      #1;
      chk("rst_req0_rdy", req0_rdy, 1'b0);
      chk("rst_req1_rdy", req1_rdy, 1'b0);
      chk("rst_memreq_val", memreq_val, 1'b0);
      chk("rst_resp0_val", resp0_val, 1'b0);
      chk("rst_resp1_val", resp1_val, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      req0_val = 1'b0; req1_val = 1'b0;
      rst = 1'b1;
      #1;
      chk("idle_memreq_val", memreq_val, 1'b0);

      // Read in flight, then reset drops the response immediately
      drive_cycle(1'b1, 16'h0010, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 32'h0, g);
      @(posedge clk);
      #1;
      chk("rd_resp0_val", resp0_val, 1'b1);
      chk("rd_resp0_data", resp0_data, 32'hDEADBEEF);
      chk("rd_resp1_val", resp1_val, 1'b0);
      rst = 1'b0;
      req0_val = 1'b0;
      #1;
      chk("midrst_resp0_val", resp0_val, 1'b0);
      chk("midrst_resp1_val", resp1_val, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      run_port = 1; run_len = BURST;
      mon_en = 1'b1;

      // Read, then a write followed by an idle cycle (no response expected)
      drive_cycle(1'b1, 16'h0010, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 32'h0, g);
      drive_cycle(1'b1, 16'h0020, 1'b1, 32'h5, 1'b0, 16'h0, 1'b0, 32'h0, g);
      drive_cycle(1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 32'h0, g);

      // Accelerator streams 8 reads alone: every one granted regardless of BURST
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b0, 16'h0, 1'b0, 32'h0, 1'b1, 16'(16'h0030 + i), 1'b0, 32'h0, g);
         chk("stream_gnt1", req1_rdy, 1'b1);
      end

      // Both ports contend for 10 cycles after port 1 has run a full burst
      tie_tbl = 10'b0011110000;
      for (int i = 0; i < 10; i++) begin
         drive_cycle(1'b1, 16'h0012, 1'b0, 32'h0, 1'b1, 16'h0023, 1'b0, 32'h0, g);
         chk("tie_gnt1", req1_rdy, tie_tbl[i]);
      end

      // Random mixed traffic; a pending request is held until it is granted
      hv[0] = 1'b0; hv[1] = 1'b0;
      drive_cycle(1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 32'h0, g);
      for (int n = 0; n < 2000; n++) begin
         for (int p = 0; p < 2; p++) begin
            if (!hv[p] && $urandom_range(0, 99) < 65) begin
               hv[p] = 1'b1;
               ha[p] = 16'(16'h0400 + $urandom_range(0, 15));
               hw[p] = ($urandom_range(0, 99) < 30);
               hd[p] = $urandom;
            end
         end
         drive_cycle(hv[0], hv[0] ? ha[0] : 16'h0, hv[0] ? hw[0] : 1'b0, hv[0] ? hd[0] : 32'h0,
                     hv[1], hv[1] ? ha[1] : 16'h0, hv[1] ? hw[1] : 1'b0, hv[1] ? hd[1] : 32'h0, g);
         if (g >= 0) hv[g] = 1'b0;
      end

      for (int i = 0; i < 3; i++)
         drive_cycle(1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 32'h0, g);
      @(negedge clk);
      #3;
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
